// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM pipeline control unit: instruction field
// values, ALU operation codes, flag bit positions, the D->E control bundle
// and the condition-code evaluator.
package arm_ctrl_pkg;

    localparam int ALUCTRL_W = 2;
    localparam int FLAGS_W   = 4;

    // Op field (InstrD[27:26])
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing cmd field (Funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition field (InstrD[31:28]); 1111 is "never"
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Flag bit positions within {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [ALUCTRL_W-1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_t;

    // Control bundle carried from Decode into Execute
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        alu_ctrl_t  alu_control;
        logic [1:0] flag_write;
        logic       branch;
        logic       pcs;
        logic [3:0] cond;
    } ctrl_t;

    function automatic logic cond_holds(input logic [3:0] cond,
                                        input logic [FLAGS_W-1:0] flags);
        logic n, z, c, v, result;
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        case (cond)
            COND_EQ: result = z;
            COND_NE: result = ~z;
            COND_CS: result = c;
            COND_CC: result = ~c;
            COND_MI: result = n;
            COND_PL: result = ~n;
            COND_VS: result = v;
            COND_VC: result = ~v;
            COND_HI: result = c & ~z;
            COND_LS: result = ~c | z;
            COND_GE: result = (n == v);
            COND_LT: result = (n != v);
            COND_GT: result = ~z & (n == v);
            COND_LE: result = z | (n != v);
            COND_AL: result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// Execute-stage condition unit: holds the NZCV flags of the last executed
// flag-setting instruction and decides whether the instruction now in
// Execute is allowed to commit its side effects.
module arm_cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         cond,
    input  logic [FLAGS_W-1:0] alu_flags,
    input  logic [1:0]         flag_write,
    output logic               cond_ex
);

    logic [FLAGS_W-1:0] flags_e;

    // Condition check uses only the stored flags, never the live ALU flags
    always_comb begin
        cond_ex = cond_holds(cond, flags_e);
    end

    // A passing instruction loads N,Z and/or C,V from the ALU at end of Execute
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_e <= '0;
        end else if (cond_ex) begin
            if (flag_write[1]) begin
                flags_e[FLAG_N] <= alu_flags[FLAG_N];
                flags_e[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (flag_write[0]) begin
                flags_e[FLAG_C] <= alu_flags[FLAG_C];
                flags_e[FLAG_V] <= alu_flags[FLAG_V];
            end
        end
    end

endmodule

// File: rtl/arm_pipe_controller.sv
// Control unit for the 5-stage pipelined ARM datapath. Decodes InstrD,
// carries control through Execute, Memory and Writeback, and gates the
// committing controls with the Execute-stage condition result.
// Build option ARM_CTRL_EARLY_BRANCH_EN: branches redirect from Execute via
// BranchTakenE instead of writing the PC in Writeback.
module arm_pipe_controller
    import arm_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          InstrD,
    input  logic [FLAGS_W-1:0]   ALUFlags,
    input  logic                 FlushE,
    output logic [1:0]           RegSrcD,
    output logic [1:0]           ImmSrcD,
    output logic                 ALUSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 BranchTakenE,
    output logic                 MemtoRegE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 MemtoRegW,
    output logic                 RegWriteW,
    output logic                 PCSrcW,
    output logic                 PCWrPendingF
);

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       unused_instr;

    ctrl_t ctrl_d;
    ctrl_t ctrl_e;
    logic  cond_ex;
    logic  pcs_into_m;

    logic reg_write_m, mem_write_m, mem_to_reg_m, pcs_m;
    logic reg_write_w, mem_to_reg_w, pcs_w;

    assign op           = InstrD[27:26];
    assign funct        = InstrD[25:20];
    assign rd           = InstrD[15:12];
    assign cmd          = funct[4:1];
    assign unused_instr = ^{InstrD[19:16], InstrD[11:0]};

    // Decode the instruction word into the control bundle and D-stage selects
    always_comb begin
        ctrl_d      = '0;
        ctrl_d.cond = InstrD[31:28];
        RegSrcD     = 2'b00;
        case (op)
            OP_DP: begin
                ctrl_d.alu_src = funct[5];
                case (cmd)
                    CMD_ADD: begin
                        ctrl_d.reg_write   = 1'b1;
                        ctrl_d.alu_control = ALU_ADD;
                        ctrl_d.flag_write  = {funct[0], funct[0]};
                    end
                    CMD_SUB: begin
                        ctrl_d.reg_write   = 1'b1;
                        ctrl_d.alu_control = ALU_SUB;
                        ctrl_d.flag_write  = {funct[0], funct[0]};
                    end
                    CMD_AND: begin
                        ctrl_d.reg_write   = 1'b1;
                        ctrl_d.alu_control = ALU_AND;
                        ctrl_d.flag_write  = {funct[0], 1'b0};
                    end
                    CMD_ORR: begin
                        ctrl_d.reg_write   = 1'b1;
                        ctrl_d.alu_control = ALU_ORR;
                        ctrl_d.flag_write  = {funct[0], 1'b0};
                    end
                    CMD_CMP: begin
                        ctrl_d.alu_control = ALU_SUB;
                        ctrl_d.flag_write  = {funct[0], funct[0]};
                    end
                    default: begin
                        ctrl_d.alu_control = ALU_ADD;
                    end
                endcase
            end
            OP_MEM: begin
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = ALU_ADD;
                if (funct[0]) begin
                    ctrl_d.reg_write  = 1'b1;
                    ctrl_d.mem_to_reg = 1'b1;
                end else begin
                    ctrl_d.mem_write = 1'b1;
                    RegSrcD[1]       = 1'b1;
                end
            end
            OP_BR: begin
                ctrl_d.branch      = 1'b1;
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = ALU_ADD;
                RegSrcD[0]         = 1'b1;
            end
            default: begin
                ctrl_d.alu_control = ALU_ADD;
            end
        endcase
        ctrl_d.pcs = ((rd == 4'd15) & ctrl_d.reg_write) | ctrl_d.branch;
    end

    assign ImmSrcD = InstrD[25:24];

    // D->E register; a flush inserts a bubble even when a new word is decoded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_e <= '0;
        end else if (FlushE) begin
            ctrl_e <= '0;
        end else begin
            ctrl_e <= ctrl_d;
        end
    end

    arm_cond_unit u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (ctrl_e.cond),
        .alu_flags  (ALUFlags),
        .flag_write (ctrl_e.flag_write),
        .cond_ex    (cond_ex)
    );

`ifdef ARM_CTRL_EARLY_BRANCH_EN
    // Taken branches redirect from Execute, so they never reach the PC write path
    assign BranchTakenE = ctrl_e.branch & cond_ex;
    assign pcs_into_m   = ctrl_e.pcs & cond_ex & ~ctrl_e.branch;
`else
    assign BranchTakenE = 1'b0;
    assign pcs_into_m   = ctrl_e.pcs & cond_ex;
`endif

    // E->M register; committing controls are killed when the condition fails
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            pcs_m        <= 1'b0;
        end else begin
            reg_write_m  <= ctrl_e.reg_write & cond_ex;
            mem_write_m  <= ctrl_e.mem_write & cond_ex;
            mem_to_reg_m <= ctrl_e.mem_to_reg;
            pcs_m        <= pcs_into_m;
        end
    end

    // M->W register for the writeback selects
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
            pcs_w        <= 1'b0;
        end else begin
            reg_write_w  <= reg_write_m;
            mem_to_reg_w <= mem_to_reg_m;
            pcs_w        <= pcs_m;
        end
    end

    assign ALUSrcE      = ctrl_e.alu_src;
    assign ALUControlE  = ctrl_e.alu_control;
    assign MemtoRegE    = ctrl_e.mem_to_reg;
    assign RegWriteM    = reg_write_m;
    assign MemWriteM    = mem_write_m;
    assign MemtoRegW    = mem_to_reg_w;
    assign RegWriteW    = reg_write_w;
    assign PCSrcW       = pcs_w;
    assign PCWrPendingF = ctrl_d.pcs | ctrl_e.pcs | pcs_m;

endmodule

// File: tb/tb_arm_pipe_controller.sv
// Self-checking bench for arm_pipe_controller. A cycle-indexed history model
// predicts every output each cycle; a set of literal expectations pins the
// headline scenarios. Honours ARM_CTRL_EARLY_BRANCH_EN when defined.
module tb_arm_pipe_controller;

`ifdef ARM_CTRL_EARLY_BRANCH_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [31:0] NOP_W = 32'hEC000000;
    localparam int          MAXC  = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD;
    logic [3:0]  ALUFlags;
    logic        FlushE;
    logic [1:0]  RegSrcD, ImmSrcD, ALUControlE;
    logic        ALUSrcE, BranchTakenE, MemtoRegE, RegWriteM, MemWriteM;
    logic        MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF;

    arm_pipe_controller dut (
        .clk          (clk),
        .reset        (reset),
        .InstrD       (InstrD),
        .ALUFlags     (ALUFlags),
        .FlushE       (FlushE),
        .RegSrcD      (RegSrcD),
        .ImmSrcD      (ImmSrcD),
        .ALUSrcE      (ALUSrcE),
        .ALUControlE  (ALUControlE),
        .BranchTakenE (BranchTakenE),
        .MemtoRegE    (MemtoRegE),
        .RegWriteM    (RegWriteM),
        .MemWriteM    (MemWriteM),
        .MemtoRegW    (MemtoRegW),
        .RegWriteW    (RegWriteW),
        .PCSrcW       (PCSrcW),
        .PCWrPendingF (PCWrPendingF)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       regw;
        logic       memw;
        logic       m2r;
        logic       alusrc;
        logic [1:0] aluctl;
        logic [1:0] flagw;
        logic       branch;
        logic       pcs;
        logic [3:0] cond;
        logic [1:0] reg_src;
        logic [1:0] imm_src;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  flags;
        logic        flush;
        logic        rst;
    } vec_t;

    vec_t vecs[$];
    dec_t e_h[MAXC];
    bit   pass_h[MAXC];
    bit   regw_m_h[MAXC], memw_m_h[MAXC], m2r_m_h[MAXC], pcs_m_h[MAXC];
    logic [3:0] mflags;

    dec_t exp_d, exp_e;
    bit   exp_taken, exp_regw_w, exp_m2r_w, exp_pcs_w, exp_pend;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Instruction meaning from the ISA tables, one mnemonic at a time
    function automatic dec_t decode(input logic [31:0] i);
        dec_t       d;
        logic [1:0] op;
        logic [5:0] f;
        logic       s;
        d       = '0;
        op      = i[27:26];
        f       = i[25:20];
        s       = f[0];
        d.cond    = i[31:28];
        d.imm_src = i[25:24];
        if (op == 2'b00) begin
            d.alusrc = f[5];
            if (f[4:1] == 4'b0100) begin
                d.regw = 1'b1; d.aluctl = 2'b00; d.flagw = {s, s};
            end else if (f[4:1] == 4'b0010) begin
                d.regw = 1'b1; d.aluctl = 2'b01; d.flagw = {s, s};
            end else if (f[4:1] == 4'b0000) begin
                d.regw = 1'b1; d.aluctl = 2'b10; d.flagw = {s, 1'b0};
            end else if (f[4:1] == 4'b1100) begin
                d.regw = 1'b1; d.aluctl = 2'b11; d.flagw = {s, 1'b0};
            end else if (f[4:1] == 4'b1010) begin
                d.aluctl = 2'b01; d.flagw = {s, s};
            end
        end else if (op == 2'b01) begin
            d.alusrc = 1'b1;
            if (f[0]) begin
                d.regw = 1'b1; d.m2r = 1'b1;
            end else begin
                d.memw = 1'b1; d.reg_src = 2'b10;
            end
        end else if (op == 2'b10) begin
            d.branch = 1'b1; d.alusrc = 1'b1; d.reg_src = 2'b01;
        end
        d.pcs = (d.regw && (i[15:12] == 4'hF)) || d.branch;
        return d;
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    task automatic addVec(input logic [31:0] instr, input logic [3:0] flags,
                          input logic flush, input logic rst);
        vec_t v;
        v.instr = instr; v.flags = flags; v.flush = flush; v.rst = rst;
        vecs.push_back(v);
    endtask

    // Fold the flag result of the instruction that finished Execute last cycle
    task automatic retireFlags(input int c);
        if (c >= 1 && pass_h[c-1]) begin
            if (e_h[c-1].flagw[1]) mflags[3:2] = vecs[c-1].flags[3:2];
            if (e_h[c-1].flagw[0]) mflags[1:0] = vecs[c-1].flags[1:0];
        end
    endtask

    // Drive cycle c and work out what each stage must show from the history
    task automatic applyStimulus(input int c);
        vec_t v;
        bit   e_ok, rm, wm, mm, pm;
        v        = vecs[c];
        reset    = !v.rst;
        InstrD   = v.instr;
        ALUFlags = v.flags;
        FlushE   = v.flush;
        if (v.rst) mflags = 4'b0000;
        exp_d = decode(v.instr);
        e_ok  = (c >= 1) && !v.rst && !vecs[c-1].rst && !vecs[c-1].flush;
        exp_e = e_ok ? decode(vecs[c-1].instr) : dec_t'('0);
        e_h[c]    = exp_e;
        pass_h[c] = e_ok && cond_ok(exp_e.cond, mflags);
        exp_taken = EARLY && exp_e.branch && pass_h[c];
        rm = 0; wm = 0; mm = 0; pm = 0;
        exp_regw_w = 0; exp_m2r_w = 0; exp_pcs_w = 0;
        if (c >= 1 && !v.rst) begin
            rm = e_h[c-1].regw && pass_h[c-1];
            wm = e_h[c-1].memw && pass_h[c-1];
            mm = e_h[c-1].m2r;
            pm = e_h[c-1].pcs && pass_h[c-1] && !(EARLY && e_h[c-1].branch);
            exp_regw_w = regw_m_h[c-1];
            exp_m2r_w  = m2r_m_h[c-1];
            exp_pcs_w  = pcs_m_h[c-1];
        end
        regw_m_h[c] = rm; memw_m_h[c] = wm; m2r_m_h[c] = mm; pcs_m_h[c] = pm;
        exp_pend = exp_d.pcs || exp_e.pcs || pm;
    endtask

    // Compare every output against the model for this cycle
    task automatic checkOutput(input int c);
        chk("RegSrcD",      RegSrcD,      exp_d.reg_src);
        chk("ImmSrcD",      ImmSrcD,      exp_d.imm_src);
        chk("ALUSrcE",      ALUSrcE,      exp_e.alusrc);
        chk("ALUControlE",  ALUControlE,  exp_e.aluctl);
        chk("BranchTakenE", BranchTakenE, exp_taken);
        chk("MemtoRegE",    MemtoRegE,    exp_e.m2r);
        chk("RegWriteM",    RegWriteM,    regw_m_h[c]);
        chk("MemWriteM",    MemWriteM,    memw_m_h[c]);
        chk("MemtoRegW",    MemtoRegW,    exp_m2r_w);
        chk("RegWriteW",    RegWriteW,    exp_regw_w);
        chk("PCSrcW",       PCSrcW,       exp_pcs_w);
        chk("PCWrPendingF", PCWrPendingF, exp_pend);
    endtask

    // Hand-derived expectations for the headline scenarios
    task automatic checkLiterals(input int c);
        logic [9:0] regd;
        regd = {ALUSrcE, ALUControlE, BranchTakenE, MemtoRegE, RegWriteM,
                MemWriteM, MemtoRegW, RegWriteW, PCSrcW};
        case (c)
            0:  chk("lit_reset_regs", regd, 10'd0);
            2:  begin chk("lit_add_aluctl", ALUControlE, 2'b00); chk("lit_add_alusrc", ALUSrcE, 1'b0); end
            4:  begin chk("lit_add_regwW", RegWriteW, 1'b1); chk("lit_add_pcsrcW", PCSrcW, 1'b0); end
            6:  begin chk("lit_subs_aluctl", ALUControlE, 2'b01); chk("lit_subs_alusrc", ALUSrcE, 1'b1); end
            7:  chk("lit_beq_taken", BranchTakenE, EARLY);
            9:  chk("lit_beq_pcsrcW", PCSrcW, !EARLY);
            13: chk("lit_strne_z1", MemWriteM, 1'b0);
            17: chk("lit_strne_z0", MemWriteM, 1'b1);
            19: chk("lit_ldr_flush_m2rE", MemtoRegE, 1'b0);
            21: begin chk("lit_ldr_flush_regwW", RegWriteW, 1'b0); chk("lit_ldr_flush_m2rW", MemtoRegW, 1'b0); end
            22: chk("lit_pcw_pend_D", PCWrPendingF, 1'b1);
            23: begin chk("lit_pcw_pend_E", PCWrPendingF, 1'b1); chk("lit_op11_regsrc", RegSrcD, 2'b00); end
            24: chk("lit_pcw_pend_M", PCWrPendingF, 1'b1);
            25: begin chk("lit_pcw_pcsrcW", PCSrcW, 1'b1); chk("lit_pcw_pend_clear", PCWrPendingF, 1'b0); end
            26: begin chk("lit_op11_regwW", RegWriteW, 1'b0); chk("lit_op11_pcsrcW", PCSrcW, 1'b0); end
            29: chk("lit_ldr_m2rE", MemtoRegE, 1'b1);
            30: begin chk("lit_midreset_regs", regd, 10'd0); chk("lit_midreset_flags", dut.u_cond.flags_e, 4'b0000); end
            35: chk("lit_addge_fail", RegWriteM, 1'b0);
            36: chk("lit_addlt_pass", RegWriteM, 1'b1);
            38: chk("lit_addgt_fail", RegWriteM, 1'b0);
            default: ;
        endcase
    endtask

    initial begin
        reset    = 1'b0;
        InstrD   = NOP_W;
        ALUFlags = 4'b0000;
        FlushE   = 1'b0;
        mflags   = 4'b0000;

        addVec(NOP_W,        4'b1111, 0, 1); // 0  reset
        addVec(32'hE0821003, 4'b1111, 0, 0); // 1  ADD R1,R2,R3
        addVec(NOP_W,        4'b1111, 0, 0); // 2
        addVec(NOP_W,        4'b1111, 0, 0); // 3
        addVec(NOP_W,        4'b1111, 0, 0); // 4
        addVec(32'hE2500001, 4'b1111, 0, 0); // 5  SUBS
        addVec(32'h0A000002, 4'b0100, 0, 0); // 6  BEQ, SUBS sets Z
        addVec(NOP_W,        4'b0000, 0, 0); // 7
        addVec(NOP_W,        4'b1111, 0, 0); // 8
        addVec(NOP_W,        4'b1111, 0, 0); // 9
        addVec(32'hE3500000, 4'b1111, 0, 0); // 10 CMP
        addVec(32'h15801000, 4'b0100, 0, 0); // 11 STRNE, CMP sets Z
        addVec(NOP_W,        4'b1111, 0, 0); // 12
        addVec(NOP_W,        4'b1111, 0, 0); // 13
        addVec(32'hE3500000, 4'b1111, 0, 0); // 14 CMP
        addVec(32'h15801000, 4'b1000, 0, 0); // 15 STRNE, CMP clears Z
        addVec(NOP_W,        4'b1111, 0, 0); // 16
        addVec(NOP_W,        4'b1111, 0, 0); // 17
        addVec(32'hE5912000, 4'b1111, 1, 0); // 18 LDR flushed entering E
        addVec(NOP_W,        4'b1111, 0, 0); // 19
        addVec(NOP_W,        4'b1111, 0, 0); // 20
        addVec(NOP_W,        4'b1111, 0, 0); // 21
        addVec(32'hE28FF004, 4'b1111, 0, 0); // 22 ADD PC,PC,#4
        addVec(NOP_W,        4'b1111, 0, 0); // 23
        addVec(NOP_W,        4'b1111, 0, 0); // 24
        addVec(NOP_W,        4'b1111, 0, 0); // 25
        addVec(NOP_W,        4'b1111, 0, 0); // 26
        addVec(32'hE0821003, 4'b1111, 0, 0); // 27 ADD
        addVec(32'hE5912000, 4'b1111, 0, 0); // 28 LDR
        addVec(32'hE28FF004, 4'b1111, 0, 0); // 29 ADD PC
        addVec(NOP_W,        4'b1111, 0, 1); // 30 reset mid-stream
        addVec(NOP_W,        4'b1111, 0, 0); // 31
        addVec(32'hE0100000, 4'b1111, 0, 0); // 32 ANDS
        addVec(32'hA0821003, 4'b1011, 0, 0); // 33 ADDGE, ANDS loads N,Z only
        addVec(32'hB0821003, 4'b1111, 0, 0); // 34 ADDLT
        addVec(32'hE0921003, 4'b1111, 0, 0); // 35 ADDS
        addVec(32'hC0821003, 4'b0011, 0, 0); // 36 ADDGT, ADDS loads all
        addVec(NOP_W,        4'b1111, 0, 0); // 37
        addVec(32'h1A000000, 4'b1111, 0, 0); // 38 BNE
        addVec(32'hE1821003, 4'b1111, 0, 0); // 39 ORR
        addVec(32'hE0421003, 4'b1111, 0, 0); // 40 SUB
        addVec(NOP_W,        4'b1111, 0, 0); // 41
        addVec(NOP_W,        4'b1111, 0, 0); // 42
        addVec(NOP_W,        4'b1111, 0, 0); // 43
        addVec(NOP_W,        4'b1111, 0, 0); // 44

        for (int c = 0; c < vecs.size(); c++) begin
            @(posedge clk);
            retireFlags(c);
            #1;
            cyc = c;
            applyStimulus(c);
            @(negedge clk);
            checkOutput(c);
            checkLiterals(c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
